ciclo_rtc: RTL and testbench
============================

Name: ciclo_rtc

Overview:
- Programmable period generator for the RTC signal-control path.
- While enabled, an internal tick counter runs from 0 to duracion-1 and then wraps.
- Each wrap marks one completed cycle; a 6-bit completed-cycle counter advances on every wrap.
- Both counters are exported for downstream sequencing of RTC bus signals.

Parameters:
- W, 6, width of duracion, cuenta_int and ciclo (all arithmetic modulo 2^W).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- EN_ciclo  input  1  count enable; 1 = run, 0 = freeze.
- duracion  input  W  period length in clocks; sampled every clock, no latching.
- ciclo  output  W  completed-period counter; registered.
- cuenta_int  output  W  position within the current period; registered.

Behaviour:
- Reset (reset=0, asynchronous): cuenta_int=0, ciclo=0 immediately. Both are held while reset is low. Counting resumes on the first rising edge with reset=1 and EN_ciclo=1.
- EN_ciclo=0: cuenta_int and ciclo both hold their values (freeze, no clear).
- EN_ciclo=1, duracion>=1, at each rising edge:
  - if cuenta_int >= duracion-1: cuenta_int <= 0 and ciclo <= ciclo+1 (wraps 63->0);
  - else: cuenta_int <= cuenta_int+1 and ciclo holds.
- duracion=1: cuenta_int stays 0 and ciclo increments every clock.
- duracion=0: period disabled. cuenta_int <= 0, ciclo holds. No increment and no wrap event.
- Period length: exactly duracion clocks between successive ciclo increments in steady state. The first increment occurs duracion clocks after enabling from cuenta_int=0.
- duracion change mid-period:
  - the new value takes effect on the next edge (compare uses current duracion);
  - if the new value <= cuenta_int+1, the wrap happens on the next edge (cuenta_int -> 0, ciclo+1);
  - if larger, the current period simply extends.
- EN_ciclo toggling: freezing mid-period resumes from the frozen cuenta_int. No increment is lost or duplicated.
- Reset mid-operation: asynchronous clear of both outputs regardless of EN_ciclo and duracion.
- No combinational path from inputs to outputs; both outputs come directly from flops.

Test Plan:
- Reset hold: reset=0 for 10 clocks with EN_ciclo=1, duracion=5 -> cuenta_int=0 and ciclo=0 throughout; assert reset asynchronously between edges -> outputs clear without waiting for a clock edge.
- Basic period: release reset, EN_ciclo=0 for 10 clocks -> outputs stay 0. Then EN_ciclo=1, duracion=5 -> cuenta_int sequence 0,1,2,3,4,0,...; ciclo increments once every 5 clocks; after 160 enabled clocks ciclo=32.
- Period change mid-run: with duracion=5 and cuenta_int=4, set duracion=3 -> next edge wraps (cuenta_int=0, ciclo+1). Thereafter the sequence is 0,1,2 with an increment every 3 clocks; 100 further clocks give 33 more increments (cuenta_int=1 at end).
- Wrap-around of ciclo: duracion=1 for 70 clocks from ciclo=0 -> ciclo=6 (63->0 wrap passed), cuenta_int=0 each clock.
- Freeze: EN_ciclo=0 at cuenta_int=2, ciclo=7 for 20 clocks -> values held. Re-enable -> continues 3,4,0 with ciclo=8 on the wrap.
- duracion=0: enable with duracion=0 -> cuenta_int=0 and ciclo unchanged for 50 clocks. Set duracion=2 -> resumes with an increment every 2 clocks.

Source files
------------

// File: rtl/ciclo_rtc.sv
// ciclo_rtc: programmable period generator with tick position and completed-cycle counters
module ciclo_rtc #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         EN_ciclo,
    input  logic [W-1:0] duracion,
    output logic [W-1:0] ciclo,
    output logic [W-1:0] cuenta_int
);
    logic         activo;
    logic         fin;
    logic [W-1:0] cuenta_nxt;
    logic [W-1:0] ciclo_nxt;

    // next-state: duracion=0 parks the tick at 0; a shrunk period wraps immediately
    always_comb begin
        activo     = EN_ciclo && (duracion != '0);
        fin        = activo && (cuenta_int >= duracion - W'(1));
        cuenta_nxt = !EN_ciclo ? cuenta_int : (!activo || fin) ? '0 : cuenta_int + W'(1);
        ciclo_nxt  = fin ? ciclo + W'(1) : ciclo;
    end

    // counter registers with asynchronous active-low clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cuenta_int <= '0;
            ciclo      <= '0;
        end else begin
            cuenta_int <= cuenta_nxt;
            ciclo      <= ciclo_nxt;
        end
    end
endmodule

// File: tb/tb_ciclo_rtc.sv
// tb_ciclo_rtc: directed test-plan steps plus randomized run against an integer period model
module tb_ciclo_rtc;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       EN_ciclo = 1'b0;
    logic [5:0] duracion = '0;
    logic [5:0] ciclo;
    logic [5:0] cuenta_int;
    int         checks = 0;
    int         failures = 0;
    int         pos = 0;
    int         cnt = 0;

    ciclo_rtc #(.W(6)) dut (
        .clk(clk),
        .reset(reset),
        .EN_ciclo(EN_ciclo),
        .duracion(duracion),
        .ciclo(ciclo),
        .cuenta_int(cuenta_int)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // model: position within a period of d clocks; a completed period bumps cnt mod 64
    task automatic model_edge();
        if (!reset) begin
            pos = 0;
            cnt = 0;
        end else if (EN_ciclo) begin
            if (duracion == 0) pos = 0;
            else if (pos + 1 >= int'(duracion)) begin
                pos = 0;
                cnt = (cnt + 1) % 64;
            end else pos = pos + 1;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            model_edge();
            #1;
            chk("cuenta_int", cuenta_int, 6'(pos));
            chk("ciclo", ciclo, 6'(cnt));
        end
    endtask

    task automatic async_reset();
        #3 reset = 1'b0;
        pos = 0;
        cnt = 0;
        #1;
        chk("async_cuenta", cuenta_int, 6'd0);
        chk("async_ciclo", ciclo, 6'd0);
    endtask

    initial begin
        EN_ciclo = 1'b1;
        duracion = 6'd5;
        tick(10);
        chk("hold_cuenta", cuenta_int, 6'd0);
        chk("hold_ciclo", ciclo, 6'd0);
        #2 reset = 1'b1;
        EN_ciclo = 1'b0;
        tick(10);
        chk("idle_ciclo", ciclo, 6'd0);
        EN_ciclo = 1'b1;
        tick(160);
        chk("basic_ciclo", ciclo, 6'd32);
        chk("basic_cuenta", cuenta_int, 6'd0);
        tick(4);
        chk("pre_change", cuenta_int, 6'd4);
        duracion = 6'd3;
        tick(1);
        chk("change_cuenta", cuenta_int, 6'd0);
        chk("change_ciclo", ciclo, 6'd33);
        tick(100);
        chk("run3_ciclo", ciclo, 6'd2);
        chk("run3_cuenta", cuenta_int, 6'd1);
        async_reset();
        #2 reset = 1'b1;
        duracion = 6'd1;
        tick(70);
        chk("wrap_ciclo", ciclo, 6'd6);
        chk("wrap_cuenta", cuenta_int, 6'd0);
        duracion = 6'd5;
        tick(7);
        chk("pre_freeze_cuenta", cuenta_int, 6'd2);
        chk("pre_freeze_ciclo", ciclo, 6'd7);
        EN_ciclo = 1'b0;
        tick(20);
        chk("freeze_cuenta", cuenta_int, 6'd2);
        chk("freeze_ciclo", ciclo, 6'd7);
        EN_ciclo = 1'b1;
        tick(1);
        chk("resume3", cuenta_int, 6'd3);
        tick(1);
        chk("resume4", cuenta_int, 6'd4);
        tick(1);
        chk("resume_wrap_cuenta", cuenta_int, 6'd0);
        chk("resume_wrap_ciclo", ciclo, 6'd8);
        duracion = 6'd0;
        tick(50);
        chk("zero_cuenta", cuenta_int, 6'd0);
        chk("zero_ciclo", ciclo, 6'd8);
        duracion = 6'd2;
        tick(2);
        chk("d2_ciclo", ciclo, 6'd9);
        tick(2);
        chk("d2_ciclo2", ciclo, 6'd10);
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) == 0) EN_ciclo = ~EN_ciclo;
            if ($urandom_range(0, 19) == 0)
                duracion = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'($urandom_range(0, 6));
            if ($urandom_range(0, 149) == 0) begin
                async_reset();
                #2 reset = 1'b1;
            end
            tick(1);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
